helen_debug_scan_slave: RTL and testbench
=========================================

Name: helen_debug_scan_slave

Overview:
Parametrised single-clock debug scan slave: the system-clock half of a virtual-JTAG debug port, generalised to NUM_CH data channels of DR_W bits, selected by an IR_W-bit instruction. It captures per-channel status into a shift register, shifts it serially on TCK-edge strobes, and on update decodes the instruction into one-cycle take_action/take_no_action pulses with the shifted word on jdo. It adds a bypass path, scan-length checking and a sticky error flag. It sits between the JTAG PHY event synchroniser and the CPU debug/OCI logic.

Parameters:
IR_W, 2, instruction register width (1..4)
DR_W, 38, data register / shift chain width (8..64)
NUM_CH, 4, number of decoded channels (1..2**IR_W); IR codes >= NUM_CH select bypass
ACT_BIT, DR_W-1, bit index of the shifted word that selects action vs no-action

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ir_in  in  IR_W  instruction from PHY, valid when vs_uir is high
vs_uir  in  1  update-IR event, one-clk pulse
vs_cdr  in  1  capture-DR event, one-clk pulse
vs_sdr  in  1  shift-DR state level
vs_udr  in  1  update-DR event, one-clk pulse
tck_rise  in  1  one-clk strobe per TCK rising edge
tdi  in  1  serial data in
tdo  out  1  serial data out
capture_data  in  NUM_CH*DR_W  channel k status at bits [k*DR_W +: DR_W]
ir_q  out  IR_W  latched instruction
jdo  out  DR_W  last updated shift word
take_action  out  NUM_CH  one-hot, one-clk pulse
take_no_action  out  NUM_CH  one-hot, one-clk pulse
scan_len_err  out  1  sticky: last DR scan length != expected
busy  out  1  high from capture until update

Behaviour:
- Reset (sync, active-high): ir_q=0, sr=0, jdo=0, tdo=0, take_action=0, take_no_action=0, scan_len_err=0, busy=0, shift_cnt=0, state=IDLE; overrides all events in that cycle.
- States: IDLE, CAPTURED, SHIFTING. Event priority in one cycle: reset > vs_uir > vs_udr > vs_cdr > shift.
- vs_uir: ir_q<=ir_in next clk; state->IDLE; busy<=0; shift_cnt<=0; no pulses. A uir during CAPTURED/SHIFTING aborts the scan; no update action follows.
- vs_cdr (any state): if ir_q<NUM_CH, sr<=capture_data[ir_q*DR_W +: DR_W]; else (bypass) sr[0]<=0. shift_cnt<=0; busy<=1; state->CAPTURED.
- Shift: when vs_sdr && tck_rise and state in CAPTURED/SHIFTING: channel mode sr<={tdi, sr[DR_W-1:1]} (LSB first); bypass sr[0]<=tdi; shift_cnt saturates at 2**8-1 (8-bit counter); state->SHIFTING. tdo registered: tdo<=sr[0] after each shift and after capture. tck_rise without vs_sdr or in IDLE: no change.
- vs_udr in CAPTURED/SHIFTING: busy<=0, state->IDLE. Expected length L=DR_W (channel) or 1 (bypass). scan_len_err<=(shift_cnt!=L), sticky until reset or a subsequent correct-length scan clears it. If channel mode and length correct: jdo<=sr; next cycle exactly one of take_action[ir_q] (sr[ACT_BIT]=1) or take_no_action[ir_q] (=0) pulses for one clk. Latency: udr at cycle N -> jdo valid and pulse at N+1. Wrong length or bypass: no pulse, jdo unchanged.
- vs_udr in IDLE: ignored, no pulse, error flag unchanged.
- Pulses never overlap; take_action|take_no_action is at most one-hot across both vectors.

Test Plan:
- Reset then idle: all outputs 0; ir_in=1 with vs_uir -> ir_q=1, no pulses.
- ir_q=2, capture_data ch2=38'h2_0000_0055, cdr, 38 shifts of tdi pattern with bit37=1, udr -> tdo stream starts 1,0,1,0,1,0,1,0 (LSB first), jdo=shifted word, take_action=4'b0100 for 1 clk, scan_len_err=0.
- Same with shifted bit37=0 -> take_no_action=4'b0100 one clk, take_action stays 0.
- 37 shifts then udr -> scan_len_err=1, no pulse, jdo unchanged; next correct 38-shift scan -> scan_len_err=0, pulse fires.
- NUM_CH=3, ir_q=3 (bypass): cdr, shift tdi=1 once -> tdo=0 then 1; udr -> no pulse, scan_len_err=0.
- vs_uir mid-SHIFTING then udr -> no pulse, busy=0; reset asserted same cycle as udr -> no pulse, all outputs 0.

Source files
------------

// File: rtl/helen_debug_scan_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// helen_debug_scan_slave : system-clock side of a virtual-JTAG debug scan port
// Revision: 1.0
// ---------------------------------------------------------------------------
module helen_debug_scan_slave #(
  parameter int IR_W    = 2,
  parameter int DR_W    = 38,
  parameter int NUM_CH  = 4,
  parameter int ACT_BIT = DR_W - 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IR_W-1:0]          ir_in,
  input  logic                     vs_uir,
  input  logic                     vs_cdr,
  input  logic                     vs_sdr,
  input  logic                     vs_udr,
  input  logic                     tck_rise,
  input  logic                     tdi,
  output logic                     tdo,
  input  logic [NUM_CH*DR_W-1:0]   capture_data,
  output logic [IR_W-1:0]          ir_q,
  output logic [DR_W-1:0]          jdo,
  output logic [NUM_CH-1:0]        take_action,
  output logic [NUM_CH-1:0]        take_no_action,
  output logic                     scan_len_err,
  output logic                     busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURED = 2'd1,
    ST_SHIFTING = 2'd2
  } state_t;

  localparam logic [IR_W:0] NUM_CH_EXT = (IR_W + 1)'(NUM_CH);
  localparam logic [7:0]    DR_LEN     = 8'(DR_W);

  state_t              state_q, state_d;
  logic [IR_W-1:0]     instr_q, instr_d;
  logic [DR_W-1:0]     sr_q, sr_d;
  logic [DR_W-1:0]     jdo_q, jdo_d;
  logic                tdo_q, tdo_d;
  logic [NUM_CH-1:0]   act_q, act_d;
  logic [NUM_CH-1:0]   noact_q, noact_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [7:0]          cnt_q, cnt_d;

  logic [DR_W-1:0]     ch_word [NUM_CH];
  logic [DR_W-1:0]     sel_word;
  logic                is_bypass;
  logic                in_scan;
  logic [7:0]          exp_len;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_word[k] = capture_data[k*DR_W +: DR_W];
  end

  // Instruction codes at or beyond NUM_CH route through the 1-bit bypass cell.
  assign is_bypass = ({1'b0, instr_q} >= NUM_CH_EXT);
  assign in_scan   = (state_q != ST_IDLE);
  assign exp_len   = is_bypass ? 8'd1 : DR_LEN;

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (instr_q == IR_W'(k)) sel_word = ch_word[k];
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    sr_d    = sr_q;
    jdo_d   = jdo_q;
    tdo_d   = tdo_q;
    act_d   = '0;
    noact_d = '0;
    err_d   = err_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;

    if (vs_uir) begin
      instr_d = ir_in;
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else if (vs_udr && in_scan) begin
      busy_d  = 1'b0;
      state_d = ST_IDLE;
      err_d   = (cnt_q != exp_len);
      if (!is_bypass && (cnt_q == exp_len)) begin
        jdo_d = sr_q;
        for (int k = 0; k < NUM_CH; k++) begin
          if (instr_q == IR_W'(k)) begin
            act_d[k]   = sr_q[ACT_BIT];
            noact_d[k] = ~sr_q[ACT_BIT];
          end
        end
      end
    end else if (vs_cdr) begin
      if (is_bypass) begin
        sr_d[0] = 1'b0;
        tdo_d   = 1'b0;
      end else begin
        sr_d  = sel_word;
        tdo_d = sel_word[0];
      end
      cnt_d   = '0;
      busy_d  = 1'b1;
      state_d = ST_CAPTURED;
    end else if (vs_sdr && tck_rise && in_scan) begin
      // tdo presents the bit now sitting in sr[0] after this shift.
      if (is_bypass) begin
        sr_d[0] = tdi;
        tdo_d   = tdi;
      end else begin
        sr_d  = {tdi, sr_q[DR_W-1:1]};
        tdo_d = sr_q[1];
      end
      cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      state_d = ST_SHIFTING;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      sr_q    <= '0;
      jdo_q   <= '0;
      tdo_q   <= 1'b0;
      act_q   <= '0;
      noact_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      sr_q    <= sr_d;
      jdo_q   <= jdo_d;
      tdo_q   <= tdo_d;
      act_q   <= act_d;
      noact_q <= noact_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ir_q           = instr_q;
  assign jdo            = jdo_q;
  assign tdo            = tdo_q;
  assign take_action    = act_q;
  assign take_no_action = noact_q;
  assign scan_len_err   = err_q;
  assign busy           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_helen_debug_scan_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_helen_debug_scan_slave : directed vector bench for the debug scan slave
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_helen_debug_scan_slave;

  localparam int IR_W   = 2;
  localparam int DR_W   = 38;
  localparam int NUM_CH = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [IR_W-1:0]        ir_in;
  logic                   vs_uir, vs_cdr, vs_sdr, vs_udr, tck_rise, tdi;
  logic                   tdo;
  logic [NUM_CH*DR_W-1:0] capture_data;
  logic [IR_W-1:0]        ir_q;
  logic [DR_W-1:0]        jdo;
  logic [NUM_CH-1:0]      take_action, take_no_action;
  logic                   scan_len_err, busy;

  int n_checks = 0;
  int n_fail   = 0;

  helen_debug_scan_slave #(
    .IR_W(IR_W), .DR_W(DR_W), .NUM_CH(NUM_CH), .ACT_BIT(DR_W - 1)
  ) dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .vs_uir(vs_uir),
    .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr), .tck_rise(tck_rise),
    .tdi(tdi), .tdo(tdo), .capture_data(capture_data), .ir_q(ir_q),
    .jdo(jdo), .take_action(take_action), .take_no_action(take_no_action),
    .scan_len_err(scan_len_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IR_W-1:0]   ir;
    logic [DR_W-1:0]   cap;
    logic [DR_W-1:0]   tdi_word;
    int                nsh;
    logic [DR_W-1:0]   exp_jdo;
    logic [NUM_CH-1:0] exp_act;
    logic [NUM_CH-1:0] exp_noact;
    logic              exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_pulses_clear(input string name);
    check(name, {58'd0, take_action, take_no_action}, 64'd0);
  endtask

  task automatic set_ir(input logic [IR_W-1:0] code);
    ir_in  = code;
    vs_uir = 1'b1;
    tick();
    vs_uir = 1'b0;
    check("ir_q", 64'(ir_q), 64'(code));
    check_pulses_clear("uir_no_pulse");
  endtask

  // Selected channel gets cap; other channels get distinct decoys.
  task automatic capture_shift(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] cap,
                               input logic [DR_W-1:0] tdi_word, input int nsh,
                               output logic [7:0] tdo_byte);
    tdo_byte = 8'd0;
    for (int k = 0; k < NUM_CH; k++)
      capture_data[k*DR_W +: DR_W] = (IR_W'(k) == ir) ? cap : (~cap ^ DR_W'(k + 1));
    vs_cdr = 1'b1;
    tick();
    vs_cdr = 1'b0;
    tdo_byte[0] = tdo;
    check("busy_after_cdr", 64'(busy), 64'd1);
    for (int i = 0; i < nsh; i++) begin
      vs_sdr   = 1'b1;
      tck_rise = 1'b1;
      tdi      = tdi_word[i];
      tick();
      if (i < 7) tdo_byte[i+1] = tdo;
    end
    vs_sdr   = 1'b0;
    tck_rise = 1'b0;
    tdi      = 1'b0;
  endtask

  task automatic pulse_udr;
    vs_udr = 1'b1;
    tick();
    vs_udr = 1'b0;
  endtask

  logic [7:0] tb_byte;

  initial begin
    vecs[0] = '{2'd2, 38'h20_0000_0055, 38'h2A_5A5A_C3C3, 38, 38'h2A_5A5A_C3C3, 3'b100, 3'b000, 1'b0};
    vecs[1] = '{2'd2, 38'h20_0000_0055, 38'h15_1234_5678, 38, 38'h15_1234_5678, 3'b000, 3'b100, 1'b0};
    vecs[2] = '{2'd2, 38'h20_0000_0055, 38'h3F_0000_FFFF, 37, 38'h15_1234_5678, 3'b000, 3'b000, 1'b1};
    vecs[3] = '{2'd2, 38'h20_0000_0055, 38'h3F_FFFF_0000, 38, 38'h3F_FFFF_0000, 3'b100, 3'b000, 1'b0};
    vecs[4] = '{2'd0, 38'h00_DEAD_BEEF, 38'h00_0000_00FF, 38, 38'h00_0000_00FF, 3'b000, 3'b001, 1'b0};
    vecs[5] = '{2'd1, 38'h01_2345_67A6, 38'h20_0000_0001, 38, 38'h20_0000_0001, 3'b010, 3'b000, 1'b0};

    reset = 1'b1; ir_in = '0; vs_uir = 0; vs_cdr = 0; vs_sdr = 0; vs_udr = 0;
    tck_rise = 0; tdi = 0; capture_data = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("reset_ir_q", 64'(ir_q), 64'd0);
    check("reset_jdo", 64'(jdo), 64'd0);
    check("reset_tdo", 64'(tdo), 64'd0);
    check("reset_err", 64'(scan_len_err), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check_pulses_clear("reset_pulses");
    set_ir(2'd1);

    for (int v = 0; v < 6; v++) begin
      set_ir(vecs[v].ir);
      capture_shift(vecs[v].ir, vecs[v].cap, vecs[v].tdi_word, vecs[v].nsh, tb_byte);
      check("tdo_stream", 64'(tb_byte), 64'(vecs[v].cap[7:0]));
      pulse_udr();
      check("udr_jdo", 64'(jdo), 64'(vecs[v].exp_jdo));
      check("udr_action", 64'(take_action), 64'(vecs[v].exp_act));
      check("udr_no_action", 64'(take_no_action), 64'(vecs[v].exp_noact));
      check("udr_len_err", 64'(scan_len_err), 64'(vecs[v].exp_err));
      check("udr_busy", 64'(busy), 64'd0);
      tick();
      check_pulses_clear("pulse_one_clk");
    end

    // Bypass: wrong length first, then a correct single-bit scan clears the error.
    set_ir(2'd3);
    capture_shift(2'd3, 38'h0F_0F0F_0F0F, 38'h3, 2, tb_byte);
    check("byp_tdo_2", 64'(tb_byte[1:0]), 64'b10);
    pulse_udr();
    check("byp_err_set", 64'(scan_len_err), 64'd1);
    check_pulses_clear("byp_no_pulse_a");
    check("byp_jdo_hold", 64'(jdo), 64'h20_0000_0001);
    capture_shift(2'd3, 38'h0F_0F0F_0F0F, 38'h1, 1, tb_byte);
    check("byp_tdo_1", 64'(tb_byte[1:0]), 64'b10);
    pulse_udr();
    check("byp_err_clr", 64'(scan_len_err), 64'd0);
    check_pulses_clear("byp_no_pulse_b");
    check("byp_busy", 64'(busy), 64'd0);

    // Update-IR mid-shift aborts; the following update-DR lands in IDLE.
    set_ir(2'd2);
    capture_shift(2'd2, 38'h20_0000_0055, 38'h3F_FFFF_FFFF, 5, tb_byte);
    check("abort_busy_pre", 64'(busy), 64'd1);
    ir_in = 2'd2; vs_uir = 1'b1;
    tick();
    vs_uir = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    pulse_udr();
    check_pulses_clear("abort_no_pulse");
    check("abort_err_hold", 64'(scan_len_err), 64'd0);
    check("abort_jdo_hold", 64'(jdo), 64'h20_0000_0001);
    tick();
    check_pulses_clear("abort_no_pulse_late");

    // Reset coincident with update-DR wins.
    capture_shift(2'd2, 38'h20_0000_0055, 38'h20_0000_0000, 38, tb_byte);
    reset = 1'b1; vs_udr = 1'b1;
    tick();
    reset = 1'b0; vs_udr = 1'b0;
    check("rst_udr_ir_q", 64'(ir_q), 64'd0);
    check("rst_udr_jdo", 64'(jdo), 64'd0);
    check("rst_udr_tdo", 64'(tdo), 64'd0);
    check("rst_udr_err", 64'(scan_len_err), 64'd0);
    check("rst_udr_busy", 64'(busy), 64'd0);
    check_pulses_clear("rst_udr_pulses");
    tick();
    check_pulses_clear("rst_udr_pulses_late");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
